spi_rx_frame_ctrl: RTL and testbench

Controller that sequences an SPI-slave receive datapath built on the team's shift-register deserializer.
- Synchronises raw sck/cs_n/mosi into clk.
- Generates the deserializer's sample-edge and cs_n-falling-edge strobes.
- Counts bits and latches each completed DW-bit word from the deserializer into a valid/ready output register.
- Flags overruns and aborted frames; sits between the SPI pins and the receiver's register/command logic.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_pin_sync.sv | 45 ++++
 rtl/spi_rx_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_spi_rx_frame_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave receive controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LOAD   = 2'd2
    } spi_rx_state_e;

    // Modes 0 and 3 sample on the rising sck edge, modes 1 and 2 on the falling edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return (cpol ^ cpha) == 1'b0;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin with a history flop and registered edge pulses.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pin_i};
        hist_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~hist_q;
        fall_d = ~sync_q[STAGES-1] & hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // The history flop is the level output so it lines up with the registered pulses.
    assign level_o = hist_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_rx_frame_ctrl.sv
// SPI slave receive sequencer: pin sync, deserializer strobes, bit counting, word handoff.
//   state  | meaning
//   IDLE   | cs_n high (or reset), sample edges ignored
//   ACTIVE | frame open, counting sample strobes toward a full word
//   LOAD   | deserializer holds a full word, hand it to the output register
module spi_rx_frame_ctrl
    import spi_pkg::*;
#(
    parameter int DW          = 8,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sck_i,
    input  logic          cs_n_i,
    input  logic          mosi_i,
    output logic          des_mosi_o,
    output logic          des_sample_o,
    output logic          des_clr_o,
    input  logic [DW-1:0] des_data_i,
    output logic [DW-1:0] rx_data_o,
    output logic          rx_valid_o,
    input  logic          rx_ready_i,
    output logic          frame_active_o,
    output logic          overrun_o,
    output logic          abort_o,
    input  logic          clear_i
);

    localparam int                CNT_W    = $clog2(DW + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DW - 1);
    localparam logic              ON_RISE  = sample_on_rise(CPOL, CPHA);

    logic sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level;
    logic sample;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (sck_i),
        .level_o (),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (cs_n_i),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (mosi_i),
        .level_o (mosi_level),
        .rise_o  (),
        .fall_o  ()
    );

    assign sample = (ON_RISE ? sck_rise : sck_fall) & ~cs_level;

    spi_rx_state_e    state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]    rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;
    logic             load_ok;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        abort_d   = 1'b0;
        case (state_q)
            IDLE: ;
            ACTIVE: begin
                if (sample) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                // The next word's first strobe may land here and must not be lost.
                state_d = ACTIVE;
                if (sample) bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            abort_d   = (bit_cnt_q != '0);
        end
        if (cs_fall) begin
            state_d   = ACTIVE;
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        load_ok    = (state_q == LOAD) && (!rx_valid_q || rx_ready_i);
        rx_data_d  = load_ok ? des_data_i : rx_data_q;
        rx_valid_d = load_ok ? 1'b1 : (rx_valid_q && !rx_ready_i);
        overrun_d  = overrun_q;
        if (clear_i) overrun_d = 1'b0;
        if ((state_q == LOAD) && !load_ok) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            abort_q    <= abort_d;
        end
    end

    assign des_mosi_o     = mosi_level;
    assign des_sample_o   = sample;
    assign des_clr_o      = cs_fall;
    assign rx_data_o      = rx_data_q;
    assign rx_valid_o     = rx_valid_q;
    assign frame_active_o = ~cs_level;
    assign overrun_o      = overrun_q;
    assign abort_o        = abort_q;

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// Bench for spi_rx_frame_ctrl: mode 0 and mode 3 instances, each with a behavioural deserializer.
module tb_spi_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck [2];
    logic       cs_n [2];
    logic       mosi [2];
    logic       des_mosi [2];
    logic       des_sample [2];
    logic       des_clr [2];
    logic [7:0] des_data [2];
    logic [7:0] rx_data [2];
    logic       rx_valid [2];
    logic       rx_ready [2];
    logic       frame_active [2];
    logic       overrun [2];
    logic       abort_p [2];
    logic       clear [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_rx_frame_ctrl #(.DW(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck[0]), .cs_n_i(cs_n[0]), .mosi_i(mosi[0]),
        .des_mosi_o(des_mosi[0]), .des_sample_o(des_sample[0]), .des_clr_o(des_clr[0]),
        .des_data_i(des_data[0]), .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]),
        .rx_ready_i(rx_ready[0]), .frame_active_o(frame_active[0]), .overrun_o(overrun[0]),
        .abort_o(abort_p[0]), .clear_i(clear[0])
    );

    spi_rx_frame_ctrl #(.DW(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sck_i(sck[1]), .cs_n_i(cs_n[1]), .mosi_i(mosi[1]),
        .des_mosi_o(des_mosi[1]), .des_sample_o(des_sample[1]), .des_clr_o(des_clr[1]),
        .des_data_i(des_data[1]), .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]),
        .rx_ready_i(rx_ready[1]), .frame_active_o(frame_active[1]), .overrun_o(overrun[1]),
        .abort_o(abort_p[1]), .clear_i(clear[1])
    );

    // External shift-register deserializers, MSB first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) des_data[0] <= 8'h00;
        else if (des_clr[0]) des_data[0] <= 8'h00;
        else if (des_sample[0]) des_data[0] <= {des_data[0][6:0], des_mosi[0]};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) des_data[1] <= 8'h00;
        else if (des_clr[1]) des_data[1] <= 8'h00;
        else if (des_sample[1]) des_data[1] <= {des_data[1][6:0], des_mosi[1]};
    end

    // Observation: event counters, accepted-word queues, valid latency after each 8th strobe.
    int         cyc = 0;
    int         n_samp [2] = '{0, 0};
    int         n_clr [2] = '{0, 0};
    int         n_abort [2] = '{0, 0};
    int         n_vrise [2] = '{0, 0};
    int         scnt [2] = '{0, 0};
    int         done_cyc [2] = '{0, 0};
    int         lat [2] = '{0, 0};
    logic       vprev [2] = '{1'b0, 1'b0};
    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (des_sample[i]) begin
                n_samp[i]++;
                scnt[i]++;
                if (scnt[i] % 8 == 0) done_cyc[i] = cyc;
            end
            if (des_clr[i]) begin
                n_clr[i]++;
                scnt[i] = 0;
            end
            if (abort_p[i]) n_abort[i]++;
            if (rx_valid[i] && !vprev[i]) begin
                n_vrise[i]++;
                lat[i] = cyc - done_cyc[i];
            end
            vprev[i] = rx_valid[i];
            if (rx_valid[i] && rx_ready[i]) begin
                if (i == 0) rxq0.push_back(rx_data[i]);
                else rxq1.push_back(rx_data[i]);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_q(input int d);
        if (d == 0) return (rxq0.size() > 0) ? {24'h0, rxq0.pop_front()} : 32'hDEAD;
        return (rxq1.size() > 0) ? {24'h0, rxq1.pop_front()} : 32'hDEAD;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? rxq0.size() : rxq1.size();
    endfunction

    task automatic cs_low(input int d);
        cs_n[d] = 1'b0;
        wclk(4);
    endtask

    task automatic cs_high(input int d);
        wclk(4);
        cs_n[d] = 1'b1;
        wclk(8);
    endtask

    // Bit time is 8 clks; sck leads low (mode 3 leaves idle-high), then rises to the sample edge.
    task automatic send_bits(input int d, input logic [7:0] w, input int nbits);
        for (int b = 7; b > 7 - nbits; b--) begin
            if (d == 1) sck[d] = 1'b0;
            mosi[d] = w[b];
            wclk(4);
            sck[d] = 1'b1;
            wclk(4);
            if (d == 0) sck[d] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_valid%0d", tag, i), {31'h0, rx_valid[i]}, 32'h0);
            check($sformatf("%s_data%0d", tag, i), {24'h0, rx_data[i]}, 32'h0);
            check($sformatf("%s_ovr%0d", tag, i), {31'h0, overrun[i]}, 32'h0);
            check($sformatf("%s_abort%0d", tag, i), {31'h0, abort_p[i]}, 32'h0);
            check($sformatf("%s_samp%0d", tag, i), {31'h0, des_sample[i]}, 32'h0);
            check($sformatf("%s_clr%0d", tag, i), {31'h0, des_clr[i]}, 32'h0);
            check($sformatf("%s_fa%0d", tag, i), {31'h0, frame_active[i]}, 32'h0);
        end
    endtask

    logic [7:0] exp_words [$];
    int         s_samp, s_clr, s_abort, s_vrise;

    initial begin
        rst_n = 1'b0;
        sck[0] = 1'b0;  sck[1] = 1'b1;
        cs_n[0] = 1'b1; cs_n[1] = 1'b1;
        mosi[0] = 1'b0; mosi[1] = 1'b0;
        rx_ready[0] = 1'b0; rx_ready[1] = 1'b0;
        clear[0] = 1'b0; clear[1] = 1'b0;
        wclk(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wclk(5);

        // Mode 0 single word, consumer always ready
        rx_ready[0] = 1'b1;
        s_samp = n_samp[0]; s_vrise = n_vrise[0]; s_abort = n_abort[0];
        cs_low(0);
        check("t1_frame_active", {31'h0, frame_active[0]}, 32'h1);
        send_bits(0, 8'hA5, 8);
        cs_high(0);
        check("t1_count", qsize(0), 1);
        check("t1_data", pop_q(0), 32'hA5);
        check("t1_vrise", n_vrise[0] - s_vrise, 1);
        check("t1_latency", lat[0], 2);
        check("t1_samples", n_samp[0] - s_samp, 8);
        check("t1_overrun", {31'h0, overrun[0]}, 32'h0);
        check("t1_abort", n_abort[0] - s_abort, 0);
        check("t1_frame_idle", {31'h0, frame_active[0]}, 32'h0);

        // Mode 3 two words in one frame
        rx_ready[1] = 1'b1;
        s_samp = n_samp[1]; s_clr = n_clr[1];
        cs_low(1);
        send_bits(1, 8'h3C, 8);
        send_bits(1, 8'hC3, 8);
        cs_high(1);
        check("t2_count", qsize(1), 2);
        check("t2_word0", pop_q(1), 32'h3C);
        check("t2_word1", pop_q(1), 32'hC3);
        check("t2_samples", n_samp[1] - s_samp, 16);
        check("t2_clr_once", n_clr[1] - s_clr, 1);
        check("t2_overrun", {31'h0, overrun[1]}, 32'h0);

        // Overrun with consumer stalled, then clear, then drain
        rx_ready[0] = 1'b0;
        cs_low(0);
        send_bits(0, 8'h11, 8);
        send_bits(0, 8'h22, 8);
        cs_high(0);
        check("t3_valid", {31'h0, rx_valid[0]}, 32'h1);
        check("t3_hold", {24'h0, rx_data[0]}, 32'h11);
        check("t3_overrun", {31'h0, overrun[0]}, 32'h1);
        check("t3_none_taken", qsize(0), 0);
        clear[0] = 1'b1;
        wclk(1);
        clear[0] = 1'b0;
        check("t3_cleared", {31'h0, overrun[0]}, 32'h0);
        check("t3_hold2", {24'h0, rx_data[0]}, 32'h11);
        rx_ready[0] = 1'b1;
        wclk(1);
        rx_ready[0] = 1'b0;
        wclk(1);
        check("t3_drain_cnt", qsize(0), 1);
        check("t3_drain", pop_q(0), 32'h11);
        check("t3_valid_low", {31'h0, rx_valid[0]}, 32'h0);

        // Abort after 5 bits, then a clean frame
        rx_ready[0] = 1'b1;
        s_abort = n_abort[0]; s_vrise = n_vrise[0]; s_clr = n_clr[0];
        cs_low(0);
        send_bits(0, 8'hF7, 5);
        cs_high(0);
        check("t4_abort", n_abort[0] - s_abort, 1);
        check("t4_no_valid", n_vrise[0] - s_vrise, 0);
        check("t4_valid_low", {31'h0, rx_valid[0]}, 32'h0);
        cs_low(0);
        send_bits(0, 8'h5A, 8);
        cs_high(0);
        check("t4_clr_fresh", n_clr[0] - s_clr, 2);
        check("t4_data", pop_q(0), 32'h5A);
        check("t4_abort_once", n_abort[0] - s_abort, 1);

        // LOAD coinciding with ready while a word is held
        rx_ready[0] = 1'b0;
        s_samp = n_samp[0]; s_vrise = n_vrise[0];
        fork
            begin
                cs_low(0);
                send_bits(0, 8'h33, 8);
                send_bits(0, 8'h44, 8);
                cs_high(0);
            end
            begin
                int k;
                k = 0;
                while (n_samp[0] < s_samp + 16 && k < 2000) begin
                    wclk(1);
                    k++;
                end
                check("t5_wait_bound", {31'h0, k < 2000}, 32'h1);
                rx_ready[0] = 1'b1;
                wclk(1);
                rx_ready[0] = 1'b0;
                check("t5_valid_kept", {31'h0, rx_valid[0]}, 32'h1);
                check("t5_new_data", {24'h0, rx_data[0]}, 32'h44);
                check("t5_no_overrun", {31'h0, overrun[0]}, 32'h0);
            end
        join
        check("t5_vrise_once", n_vrise[0] - s_vrise, 1);
        rx_ready[0] = 1'b1;
        wclk(2);
        check("t5_count", qsize(0), 2);
        check("t5_first", pop_q(0), 32'h33);
        check("t5_second", pop_q(0), 32'h44);

        // Reset mid-word while a word is held
        rx_ready[0] = 1'b0;
        cs_low(0);
        send_bits(0, 8'h77, 8);
        send_bits(0, 8'hF0, 4);
        check("t6_pre_valid", {31'h0, rx_valid[0]}, 32'h1);
        rst_n = 1'b0;
        cs_n[0] = 1'b1; sck[0] = 1'b0; mosi[0] = 1'b0;
        wclk(1);
        check_reset_outputs("t6_rst");
        wclk(2);
        rst_n = 1'b1;
        wclk(5);
        rxq0.delete();
        rx_ready[0] = 1'b1;
        s_clr = n_clr[0]; s_abort = n_abort[0];
        cs_low(0);
        send_bits(0, 8'h81, 8);
        cs_high(0);
        check("t6_count", qsize(0), 1);
        check("t6_data", pop_q(0), 32'h81);
        check("t6_clr", n_clr[0] - s_clr, 1);
        check("t6_abort", n_abort[0] - s_abort, 0);

        // Random words: ready held high means every word in send order is delivered
        for (int d = 0; d < 2; d++) begin
            exp_words.delete();
            rx_ready[d] = 1'b1;
            cs_low(d);
            for (int w = 0; w < 5; w++) begin
                exp_words.push_back(8'($urandom));
                send_bits(d, exp_words[w], 8);
            end
            cs_high(d);
            check($sformatf("rnd%0d_count", d), qsize(d), exp_words.size());
            for (int w = 0; w < 5; w++)
                check($sformatf("rnd%0d_w%0d", d, w), pop_q(d), {24'h0, exp_words[w]});
        end

        // Random words with ready held low: only the first survives and overrun is flagged
        exp_words.delete();
        rx_ready[1] = 1'b0;
        cs_low(1);
        for (int w = 0; w < 3; w++) begin
            exp_words.push_back(8'($urandom));
            send_bits(1, exp_words[w], 8);
        end
        cs_high(1);
        check("rnds_hold", {24'h0, rx_data[1]}, {24'h0, exp_words[0]});
        check("rnds_overrun", {31'h0, overrun[1]}, 32'h1);
        rx_ready[1] = 1'b1;
        wclk(2);
        check("rnds_drain", pop_q(1), {24'h0, exp_words[0]});
        check("rnds_empty", qsize(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
